unidade_controle_exp5: RTL and testbench
========================================

UNIDADE_CONTROLE_EXP5 -- requirements
Module: unidade_controle_exp5

Interface
REQ-001 Parameter TIMEOUT, default 5000, is the number of clock cycles allowed in ESPERA before a timeout (5 s at 1 kHz); legal range 2..65535.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 iniciar  input  1  start request, level, sampled each cycle.
REQ-005 jogada  input  1  one-cycle pulse from the datapath edge detector: a switch was pressed.
REQ-006 igual  input  1  datapath comparator: registered switches equal the memory word.
REQ-007 fimC  input  1  datapath address counter is at its last position.
REQ-008 zeraC  output  1  clears the datapath address counter.
REQ-009 contaC  output  1  increments the datapath address counter.
REQ-010 zeraR  output  1  clears the switch register.
REQ-011 registraR  output  1  loads the switch register.
REQ-012 acertou, errou, pronto, timeout  output  1 each  game result flags.
REQ-013 db_estado  output  4  current state code, for the 7-segment debug display.

Function
REQ-014 The block SHALL be a Moore FSM; every output SHALL depend only on the current state (and, for timeout, on the state alone).
REQ-015 State codes SHALL be: INICIAL 0000, PREPARACAO 0001, ESPERA 0010, REGISTRA 0100, COMPARACAO 0101, PROXIMO 0110, FIM_ACERTO 1010, FIM_ERRO 1110, FIM_TIMEOUT 1101; all other codes SHALL go to INICIAL on the next clock.
REQ-016 INICIAL: all outputs 0; iniciar=1 -> PREPARACAO, else stay.
REQ-017 PREPARACAO: zeraC=1, zeraR=1 for exactly one cycle; always -> ESPERA.
REQ-018 ESPERA: jogada=1 -> REGISTRA; else if the timeout counter equals TIMEOUT-1 -> FIM_TIMEOUT; else stay. jogada SHALL win over the timeout when both occur in the same cycle.
REQ-019 REGISTRA: registraR=1 for exactly one cycle; always -> COMPARACAO.
REQ-020 COMPARACAO: igual=0 -> FIM_ERRO; igual=1 and fimC=1 -> FIM_ACERTO; igual=1 and fimC=0 -> PROXIMO.
REQ-021 PROXIMO: contaC=1 for exactly one cycle; always -> ESPERA.
REQ-022 FIM_ACERTO: pronto=1, acertou=1. FIM_ERRO: pronto=1, errou=1. FIM_TIMEOUT: pronto=1, errou=1, timeout=1. From any FIM state, iniciar=1 -> PREPARACAO, else stay.
REQ-023 Timeout counter: 16-bit, internal; increments by 1 each cycle in ESPERA; cleared to 0 in every other state; never wraps inside ESPERA, because it leaves ESPERA at TIMEOUT-1.
REQ-024 Latency: jogada pulse to the result of the comparison = 3 cycles (REGISTRA, COMPARACAO, then PROXIMO or FIM).
REQ-025 iniciar, jogada, igual and fimC SHALL be ignored in any state where REQ-016..REQ-022 do not list them.
REQ-026 If iniciar is held high for several cycles, the game SHALL start once; after PREPARACAO it is ignored until a FIM state.
REQ-027 db_estado SHALL equal the state code of REQ-015.

Reset
REQ-028 reset=1 SHALL force INICIAL immediately, without waiting for a clock, from any state, mid-game included.
REQ-029 During and after reset, until the next state change: every output SHALL be 0, db_estado=0000, and the timeout counter SHALL be 0.

Verification
REQ-030 Reset pulse during ESPERA (db_estado=0010) -> db_estado=0000 before the next rising edge; every output 0.
REQ-031 iniciar=1 for 5 cycles -> exactly one cycle of PREPARACAO with zeraC=zeraR=1, then ESPERA; no second PREPARACAO.
REQ-032 TIMEOUT=20; 4 correct plays (jogada pulse, igual=1, fimC=0,0,0,1) -> contaC pulses 3 times; FIM_ACERTO; acertou=1, pronto=1, errou=0.
REQ-033 TIMEOUT=20; third play with igual=0 -> FIM_ERRO 2 cycles after REGISTRA; errou=1, pronto=1, acertou=0, timeout=0.
REQ-034 TIMEOUT=20; no jogada -> FIM_TIMEOUT exactly 20 cycles after entering ESPERA; timeout=1, errou=1. A second run with jogada in the 20th cycle -> REGISTRA, no timeout.
REQ-035 iniciar=1 in FIM_ERRO -> PREPARACAO, counter cleared, then a full winning game completes in FIM_ACERTO.

Source files
------------

// File: rtl/unidade_controle_exp5.sv
// Control unit for the memory-play game: Moore FSM that sequences the
// datapath (address counter, switch register) and times out idle waits.
module unidade_controle_exp5 #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARACAO  = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTO  = 4'b1010,
    FIM_ERRO    = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] tcount;

  // State register, reset forces INICIAL without waiting for a clock edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INICIAL;
    else       state <= next_state;
  end

  // Idle counter: counts only while remaining in ESPERA, zero everywhere else
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                       tcount <= '0;
    else if (state == ESPERA && next_state == ESPERA) tcount <= tcount + 16'd1;
    else                                              tcount <= '0;
  end

  // Next-state logic and Moore outputs decoded from the current state
  always_comb begin
    next_state = INICIAL;
    zeraC      = 1'b0;
    contaC     = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    pronto     = 1'b0;
    timeout    = 1'b0;
    case (state)
      INICIAL: next_state = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: begin
        zeraC      = 1'b1;
        zeraR      = 1'b1;
        next_state = ESPERA;
      end
      ESPERA: begin
        // a play in the last allowed cycle still counts
        if (jogada)               next_state = REGISTRA;
        else if (tcount == TLAST) next_state = FIM_TIMEOUT;
        else                      next_state = ESPERA;
      end
      REGISTRA: begin
        registraR  = 1'b1;
        next_state = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)    next_state = FIM_ERRO;
        else if (fimC) next_state = FIM_ACERTO;
        else           next_state = PROXIMO;
      end
      PROXIMO: begin
        contaC     = 1'b1;
        next_state = ESPERA;
      end
      FIM_ACERTO: begin
        pronto     = 1'b1;
        acertou    = 1'b1;
        next_state = iniciar ? PREPARACAO : FIM_ACERTO;
      end
      FIM_ERRO: begin
        pronto     = 1'b1;
        errou      = 1'b1;
        next_state = iniciar ? PREPARACAO : FIM_ERRO;
      end
      FIM_TIMEOUT: begin
        pronto     = 1'b1;
        errou      = 1'b1;
        timeout    = 1'b1;
        next_state = iniciar ? PREPARACAO : FIM_TIMEOUT;
      end
      default: next_state = INICIAL;
    endcase
  end

  assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle_exp5.sv
// Directed bench for the game control unit, built with TIMEOUT=20.
module tb_unidade_controle_exp5;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic       timeout;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // expected state codes
  localparam logic [3:0] S_INI = 4'b0000;
  localparam logic [3:0] S_PRE = 4'b0001;
  localparam logic [3:0] S_ESP = 4'b0010;
  localparam logic [3:0] S_REG = 4'b0100;
  localparam logic [3:0] S_CMP = 4'b0101;
  localparam logic [3:0] S_PRX = 4'b0110;
  localparam logic [3:0] S_ACE = 4'b1010;
  localparam logic [3:0] S_ERR = 4'b1110;
  localparam logic [3:0] S_TMO = 4'b1101;

  // expected outputs {zeraC,contaC,zeraR,registraR,acertou,errou,pronto,timeout}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_PRE  = 8'b1010_0000;
  localparam logic [7:0] O_PRX  = 8'b0100_0000;
  localparam logic [7:0] O_REG  = 8'b0001_0000;
  localparam logic [7:0] O_ACE  = 8'b0000_1010;
  localparam logic [7:0] O_ERR  = 8'b0000_0110;
  localparam logic [7:0] O_TMO  = 8'b0000_0111;

  logic [7:0] outs;
  assign outs = {zeraC, contaC, zeraR, registraR, acertou, errou, pronto, timeout};

  unidade_controle_exp5 #(.TIMEOUT(20)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fimC      (fimC),
    .zeraC     (zeraC),
    .contaC    (contaC),
    .zeraR     (zeraR),
    .registraR (registraR),
    .acertou   (acertou),
    .errou     (errou),
    .pronto    (pronto),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // one rising edge, then settle on the falling edge for sampling
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (contaC === 1'b1) pulses++;
  endtask

  task automatic chk(input string tag, input logic [3:0] es, input logic [7:0] eo);
    total++;
    assert (db_estado === es) else begin
      bad++;
      $error("FAIL %s db_estado observed=%b expected=%b", tag, db_estado, es);
    end
    total++;
    assert (outs === eo) else begin
      bad++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, outs, eo);
    end
  endtask

  // one play from ESPERA: REGISTRA, COMPARACAO, then the given result state
  task automatic play(input logic ig, input logic fc, input logic [3:0] es, input logic [7:0] eo);
    jogada = 1'b1;
    igual  = ig;
    fimC   = fc;
    tick();
    chk("registra", S_REG, O_REG);
    jogada = 1'b0;
    tick();
    chk("comparacao", S_CMP, O_NONE);
    tick();
    chk("resultado", es, eo);
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick();
    chk("preparacao", S_PRE, O_PRE);
    iniciar = 1'b0;
    tick();
    chk("espera_entry", S_ESP, O_NONE);
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("reset", S_INI, O_NONE);
    reset = 1'b0;

    // idle, and jogada is ignored in INICIAL
    jogada = 1'b1;
    tick();
    chk("idle", S_INI, O_NONE);
    jogada = 1'b0;

    // iniciar held for 5 edges: one PREPARACAO, then ESPERA only
    iniciar = 1'b1;
    tick();
    chk("hold_prep", S_PRE, O_PRE);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_espera", S_ESP, O_NONE);
    end
    iniciar = 1'b0;

    // asynchronous reset in ESPERA, checked before the next rising edge
    reset = 1'b1;
    #2;
    chk("async_reset", S_INI, O_NONE);
    reset = 1'b0;
    tick();
    chk("after_reset", S_INI, O_NONE);

    // winning game: four correct plays, contaC pulses three times
    start_game();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      play(1'b1, 1'b0, S_PRX, O_PRX);
      tick();
      chk("back_espera", S_ESP, O_NONE);
    end
    play(1'b1, 1'b1, S_ACE, O_ACE);
    total++;
    assert (pulses === 3) else begin
      bad++;
      $error("FAIL contaC_pulses observed=%0d expected=%0d", pulses, 3);
    end
    jogada = 1'b1;
    tick();
    chk("acerto_hold", S_ACE, O_ACE);
    jogada = 1'b0;

    // losing game: third play mismatches (fimC high must not matter)
    start_game();
    for (int i = 0; i < 2; i++) begin
      play(1'b1, 1'b0, S_PRX, O_PRX);
      tick();
      chk("back_espera_e", S_ESP, O_NONE);
    end
    play(1'b0, 1'b1, S_ERR, O_ERR);
    tick();
    chk("erro_hold", S_ERR, O_ERR);

    // restart from FIM_ERRO and win a full game
    start_game();
    for (int i = 0; i < 3; i++) begin
      play(1'b1, 1'b0, S_PRX, O_PRX);
      tick();
      chk("back_espera_r", S_ESP, O_NONE);
    end
    play(1'b1, 1'b1, S_ACE, O_ACE);

    // timeout: 20 cycles in ESPERA with no play
    start_game();
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("wait_espera", S_ESP, O_NONE);
    end
    tick();
    chk("timeout", S_TMO, O_TMO);
    tick();
    chk("timeout_hold", S_TMO, O_TMO);

    // play arriving in the 20th cycle wins over the timeout
    start_game();
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("wait_espera2", S_ESP, O_NONE);
    end
    play(1'b1, 1'b1, S_ACE, O_ACE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
